// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   Instruction fetch sequencer. Resets the program counter, fetches one
//   instruction word from memory into IR, holds it until the decoder asks for
//   the next address, then drives one address-mode select for a single cycle
//   and loads the resulting address (ALout) into the program counter.
//
//   The block does no arithmetic on addresses. It only chooses an address mode
//   and samples whatever the external address logic presents on ALout.
//
// Ports:
//   clk          in   1   clock; all state changes on the rising edge
//   rst          in   1   synchronous, active-high reset
//   ALout        in  16   address from the external address logic
//   PCside       out 16   program counter register, fed back to address logic
//   Iside        out  8   immediate field, IR[7:0]
//   ResetPC      out  1   select: reset address
//   PCplus1      out  1   select: PC + 1
//   PCplusI      out  1   select: PC + immediate
//   Iplus0       out  1   select: immediate
//   Rplus0       out  1   select: register
//   mem_addr     out 16   fetch address (the program counter)
//   mem_rd       out  1   read request, held high for the whole fetch
//   mem_ack      in   1   read complete; mem_data is valid with it
//   mem_data     in  16   read data
//   IR           out 16   instruction register
//   instr_valid  out  1   IR holds an instruction not yet consumed
//   next_valid   in   1   decoder requests the next address
//   next_mode    in   3   requested address mode
//   next_ready   out  1   request accepted this cycle (HOLD only)
//   fetch_err    out  1   one-cycle pulse: fetch timed out
//   mode_err     out  1   one-cycle pulse: illegal mode, PC+1 used instead
//   o_dbg_state  out  2   current FSM state, for debug and checkers
//
// Decoder handshake:
//   A next-address request transfers on a cycle where next_valid and
//   next_ready are both high. next_ready is high only in HOLD. next_valid may
//   be driven in any state; outside HOLD it is simply not looked at, so the
//   decoder may keep it asserted until it sees next_ready.
//
// Memory handshake:
//   mem_rd is held high for every FETCH cycle with mem_addr stable. The first
//   cycle with mem_ack high completes the read. mem_ack in any other state is
//   ignored, which also discards an acknowledge that arrives after a reset
//   abandoned the read.
//
// Reset:
//   While rst is high every combinational output is forced to 0, including
//   ResetPC, so ResetPC first rises in the cycle after rst is released.
// -----------------------------------------------------------------------------
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALout,
    output logic [15:0] PCside,
    output logic [7:0]  Iside,
    output logic        ResetPC,
    output logic        PCplus1,
    output logic        PCplusI,
    output logic        Iplus0,
    output logic        Rplus0,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] IR,
    output logic        instr_valid,
    input  logic        next_valid,
    input  logic [2:0]  next_mode,
    output logic        next_ready,
    output logic        fetch_err,
    output logic        mode_err,
    output logic [1:0]  o_dbg_state
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_RSTPC  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Address modes as seen on next_mode.
    localparam logic [2:0] MODE_PC_PLUS_1 = 3'd0;
    localparam logic [2:0] MODE_PC_PLUS_I = 3'd1;
    localparam logic [2:0] MODE_I_PLUS_0  = 3'd2;
    localparam logic [2:0] MODE_R_PLUS_0  = 3'd3;
    localparam logic [2:0] MODE_RESET_PC  = 3'd4;

    // The wait counter reads 0 in the first FETCH cycle, so it reads 14 in
    // the 15th cycle: that is the last cycle an acknowledge is accepted.
    localparam logic [3:0] WAIT_LAST = 4'd14;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic        r_instr_valid;
    logic [3:0]  r_wait;
    logic [2:0]  r_mode;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    state_t      w_next_state;
    logic        w_in_fetch;
    logic        w_in_hold;
    logic        w_in_update;
    logic        w_fetch_done;
    logic        w_wait_last;
    logic        w_timeout;
    logic        w_accept;
    logic        w_reset_pc;
    logic        w_pc_plus_1;
    logic        w_pc_plus_i;
    logic        w_i_plus_0;
    logic        w_r_plus_0;
    logic        w_mode_err;

    assign w_in_fetch   = (r_state == ST_FETCH);
    assign w_in_hold    = (r_state == ST_HOLD);
    assign w_in_update  = (r_state == ST_UPDATE);

    assign w_wait_last  = (r_wait == WAIT_LAST);

    // An acknowledge in the last allowed cycle wins over the timeout.
    assign w_fetch_done = w_in_fetch && mem_ack;
    assign w_timeout    = w_in_fetch && !mem_ack && w_wait_last;

    assign w_accept     = w_in_hold && next_valid;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RSTPC: begin
                w_next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    w_next_state = ST_HOLD;
                end else if (w_wait_last) begin
                    w_next_state = ST_RSTPC;
                end
            end
            ST_HOLD: begin
                if (next_valid) begin
                    w_next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_next_state = ST_FETCH;
            end
            default: begin
                w_next_state = ST_RSTPC;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address-mode select decode
    //
    // RSTPC drives ResetPC. UPDATE drives exactly one select from the latched
    // mode; modes 5-7 fall back to PC+1 and raise mode_err. FETCH and HOLD
    // drive no select at all.
    // -------------------------------------------------------------------------
    always_comb begin
        w_reset_pc  = 1'b0;
        w_pc_plus_1 = 1'b0;
        w_pc_plus_i = 1'b0;
        w_i_plus_0  = 1'b0;
        w_r_plus_0  = 1'b0;
        w_mode_err  = 1'b0;

        if (r_state == ST_RSTPC) begin
            w_reset_pc = 1'b1;
        end else if (w_in_update) begin
            case (r_mode)
                MODE_PC_PLUS_1: w_pc_plus_1 = 1'b1;
                MODE_PC_PLUS_I: w_pc_plus_i = 1'b1;
                MODE_I_PLUS_0:  w_i_plus_0  = 1'b1;
                MODE_R_PLUS_0:  w_r_plus_0  = 1'b1;
                MODE_RESET_PC:  w_reset_pc  = 1'b1;
                default: begin
                    w_pc_plus_1 = 1'b1;
                    w_mode_err  = 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RSTPC;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Program counter
    //
    // Loaded from ALout at the end of RSTPC and of UPDATE, bit for bit; any
    // wrap-around is the address logic's business.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= 16'h0000;
        end else if ((r_state == ST_RSTPC) || w_in_update) begin
            r_pc <= ALout;
        end
    end

    // -------------------------------------------------------------------------
    // Instruction register and valid flag
    //
    // IR changes only on an acknowledge inside FETCH. instr_valid is set by
    // that acknowledge and cleared when the decoder's request is accepted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir          <= 16'h0000;
            r_instr_valid <= 1'b0;
        end else if (w_fetch_done) begin
            r_ir          <= mem_data;
            r_instr_valid <= 1'b1;
        end else if (w_accept) begin
            r_instr_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Fetch wait counter
    //
    // Cleared on the way into FETCH (from RSTPC or UPDATE) and advanced on
    // every FETCH cycle without an acknowledge. It never needs to go past
    // WAIT_LAST because FETCH is left in that cycle either way.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 4'd0;
        end else if ((r_state == ST_RSTPC) || w_in_update) begin
            r_wait <= 4'd0;
        end else if (w_in_fetch && !mem_ack && !w_wait_last) begin
            r_wait <= r_wait + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Latched address mode, captured when the decoder request is accepted
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= 3'd0;
        end else if (w_accept) begin
            r_mode <= next_mode;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    //
    // Registered values are presented directly. Everything decoded from the
    // state is masked while rst is high so that no select, request or error
    // can escape during reset, even in the cycle before reset takes effect.
    // -------------------------------------------------------------------------
    assign PCside      = r_pc;
    assign IR          = r_ir;
    assign Iside       = r_ir[7:0];
    assign mem_addr    = rst ? 16'h0000 : r_pc;

    assign instr_valid = r_instr_valid && !rst;
    assign mem_rd      = w_in_fetch    && !rst;
    assign next_ready  = w_in_hold     && !rst;
    assign fetch_err   = w_timeout     && !rst;
    assign mode_err    = w_mode_err    && !rst;

    assign ResetPC     = w_reset_pc    && !rst;
    assign PCplus1     = w_pc_plus_1   && !rst;
    assign PCplusI     = w_pc_plus_i   && !rst;
    assign Iplus0      = w_i_plus_0    && !rst;
    assign Rplus0      = w_r_plus_0    && !rst;

    assign o_dbg_state = rst ? 2'd0 : r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A behavioural model tracks the
// sequencer's phase, program counter, instruction register and the number of
// fetch cycles spent so far, and a compare process checks every output
// against it on every falling edge. Fetched words are also queued and matched
// against IR each time instr_valid rises. The directed sequence adds literal
// checks for the key scenarios of the block.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    // ---------------------------------------------------------------------
    // Clock / reset / DUT signals
    // ---------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ALout;
    logic [15:0] PCside;
    logic [7:0]  Iside;
    logic        ResetPC;
    logic        PCplus1;
    logic        PCplusI;
    logic        Iplus0;
    logic        Rplus0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic [15:0] IR;
    logic        instr_valid;
    logic        next_valid;
    logic [2:0]  next_mode;
    logic        next_ready;
    logic        fetch_err;
    logic        mode_err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .ALout       (ALout),
        .PCside      (PCside),
        .Iside       (Iside),
        .ResetPC     (ResetPC),
        .PCplus1     (PCplus1),
        .PCplusI     (PCplusI),
        .Iplus0      (Iplus0),
        .Rplus0      (Rplus0),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .IR          (IR),
        .instr_valid (instr_valid),
        .next_valid  (next_valid),
        .next_mode   (next_mode),
        .next_ready  (next_ready),
        .fetch_err   (fetch_err),
        .mode_err    (mode_err),
        .o_dbg_state (dbg_state)
    );

    // ---------------------------------------------------------------------
    // Result bookkeeping
    // ---------------------------------------------------------------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    //
    // Phases follow the sequencer's documented behaviour: reset the PC, fetch
    // for up to fifteen cycles, hold the instruction, update the PC.
    // ---------------------------------------------------------------------
    localparam int PH_RESETPC = 10;
    localparam int PH_FETCH   = 20;
    localparam int PH_HOLD    = 30;
    localparam int PH_UPDATE  = 40;
    localparam int FETCH_BUDGET = 15;

    bit          m_on    = 1'b0;
    int          m_phase = PH_RESETPC;
    logic [15:0] m_pc    = 16'h0;
    logic [15:0] m_ir    = 16'h0;
    logic        m_iv    = 1'b0;
    int          m_spent = 0;      // fetch cycles already used in this fetch
    logic [2:0]  m_mode  = 3'd0;

    logic [15:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            m_on    <= 1'b1;
            m_phase <= PH_RESETPC;
            m_pc    <= 16'h0;
            m_ir    <= 16'h0;
            m_iv    <= 1'b0;
            m_spent <= 0;
            m_mode  <= 3'd0;
        end else if (m_on) begin
            if (m_phase == PH_RESETPC || m_phase == PH_UPDATE) begin
                m_pc    <= ALout;
                m_spent <= 0;
                m_phase <= PH_FETCH;
            end else if (m_phase == PH_FETCH) begin
                if (mem_ack) begin
                    m_ir    <= mem_data;
                    m_iv    <= 1'b1;
                    exp_q.push_back(mem_data);
                    m_phase <= PH_HOLD;
                end else if (m_spent + 1 == FETCH_BUDGET) begin
                    m_phase <= PH_RESETPC;
                end else begin
                    m_spent <= m_spent + 1;
                end
            end else if (m_phase == PH_HOLD && next_valid) begin
                m_mode  <= next_mode;
                m_iv    <= 1'b0;
                m_phase <= PH_UPDATE;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Compare process: every output, every cycle, on the falling edge
    // ---------------------------------------------------------------------
    logic prev_iv = 1'b0;

    always @(negedge clk) begin
        logic        live;
        logic        upd;
        logic        e_rpc;
        logic        e_p1;
        logic        e_pi;
        logic        e_i0;
        logic        e_r0;
        logic        e_rd;
        logic        e_ferr;
        logic        e_merr;
        logic        e_nr;
        logic        e_iv;
        logic [15:0] e_word;
        if (m_on) begin
            live   = !rst;
            upd    = live && (m_phase == PH_UPDATE);
            e_rpc  = live && ((m_phase == PH_RESETPC) || (upd && m_mode == 3'd4));
            e_p1   = upd && (m_mode == 3'd0 || m_mode >= 3'd5);
            e_pi   = upd && (m_mode == 3'd1);
            e_i0   = upd && (m_mode == 3'd2);
            e_r0   = upd && (m_mode == 3'd3);
            e_merr = upd && (m_mode >= 3'd5);
            e_rd   = live && (m_phase == PH_FETCH);
            e_ferr = e_rd && !mem_ack && (m_spent + 1 == FETCH_BUDGET);
            e_nr   = live && (m_phase == PH_HOLD);
            e_iv   = live && m_iv;

            chk1("ResetPC", ResetPC, e_rpc);
            chk1("PCplus1", PCplus1, e_p1);
            chk1("PCplusI", PCplusI, e_pi);
            chk1("Iplus0", Iplus0, e_i0);
            chk1("Rplus0", Rplus0, e_r0);
            chk1("sel_at_most_one",
                 ($countones({ResetPC, PCplus1, PCplusI, Iplus0, Rplus0}) <= 1), 1'b1);
            chk1("mem_rd", mem_rd, e_rd);
            if (e_rd) chk16("mem_addr", mem_addr, m_pc);
            chk1("fetch_err", fetch_err, e_ferr);
            chk1("mode_err", mode_err, e_merr);
            chk1("next_ready", next_ready, e_nr);
            chk1("instr_valid", instr_valid, e_iv);
            chk16("PCside", PCside, m_pc);
            chk16("IR", IR, m_ir);
            chk16("Iside", {8'h00, Iside}, {8'h00, m_ir[7:0]});

            // Scoreboard: each new valid instruction must be the next fetched word.
            if (instr_valid && !prev_iv) begin
                if (exp_q.size() == 0) begin
                    chk1("sb_spurious_valid", 1'b1, 1'b0);
                end else begin
                    e_word = exp_q.pop_front();
                    chk16("sb_fetched_word", IR, e_word);
                end
            end
            prev_iv <= instr_valid;
        end
    end

    // ---------------------------------------------------------------------
    // Driver helpers
    // ---------------------------------------------------------------------
    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // ---------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ---------------------------------------------------------------------
    initial begin
        rst        = 1'b1;
        ALout      = 16'h0000;
        mem_ack    = 1'b0;
        mem_data   = 16'h0000;
        next_valid = 1'b0;
        next_mode  = 3'd0;

        // Reset held: everything quiet, registers cleared.
        repeat (3) nc();
        mid();
        chk1("rst_ResetPC", ResetPC, 1'b0);
        chk1("rst_mem_rd", mem_rd, 1'b0);
        chk1("rst_next_ready", next_ready, 1'b0);
        chk1("rst_instr_valid", instr_valid, 1'b0);
        chk16("rst_PCside", PCside, 16'h0000);
        chk16("rst_IR", IR, 16'h0000);

        // Release: RSTPC cycle with ALout = 0.
        nc(); rst = 1'b0; ALout = 16'h0000;
        mid();
        chk1("rel_ResetPC", ResetPC, 1'b1);
        chk1("rel_mem_rd", mem_rd, 1'b0);

        // FETCH cycle 1: reads from address 0.
        nc(); ALout = 16'h5555;
        mid();
        chk1("f1_mem_rd", mem_rd, 1'b1);
        chk16("f1_mem_addr", mem_addr, 16'h0000);
        chk16("f1_PCside", PCside, 16'h0000);

        // FETCH cycle 2: a next-address request here is ignored.
        nc(); next_valid = 1'b1; next_mode = 3'd3;
        mid();
        chk1("f2_next_ready", next_ready, 1'b0);
        // FETCH cycle 3: acknowledge.
        nc(); next_valid = 1'b0; mem_ack = 1'b1; mem_data = 16'h12A5;
        // HOLD.
        nc(); mem_ack = 1'b0; mem_data = 16'h0000;
        mid();
        chk16("hold_IR", IR, 16'h12A5);
        chk16("hold_Iside", {8'h00, Iside}, 16'h00A5);
        chk1("hold_instr_valid", instr_valid, 1'b1);
        chk1("hold_next_ready", next_ready, 1'b1);

        // Still HOLD; an acknowledge here must not touch IR.
        nc(); mem_ack = 1'b1; mem_data = 16'hDEAD;
        mid();
        chk1("hold2_next_ready", next_ready, 1'b1);
        nc(); mem_ack = 1'b0; next_valid = 1'b1; next_mode = 3'd1;
        mid();
        chk16("hold3_IR_kept", IR, 16'h12A5);

        // UPDATE, mode 1.
        nc(); next_valid = 1'b0; ALout = 16'h00A6;
        mid();
        chk1("upd1_PCplusI", PCplusI, 1'b1);
        chk1("upd1_instr_valid", instr_valid, 1'b0);

        // FETCH at the new PC, acknowledged immediately.
        nc(); ALout = 16'h1234; mem_ack = 1'b1; mem_data = 16'hBEEF;
        mid();
        chk1("upd1_PCplusI_gone", PCplusI, 1'b0);
        chk16("upd1_PCside", PCside, 16'h00A6);
        chk16("upd1_mem_addr", mem_addr, 16'h00A6);

        // HOLD -> UPDATE mode 2 with ALout = FFFF.
        nc(); mem_ack = 1'b0; next_valid = 1'b1; next_mode = 3'd2;
        nc(); next_valid = 1'b0; ALout = 16'hFFFF;
        mid();
        chk1("upd2_Iplus0", Iplus0, 1'b1);
        nc(); mem_ack = 1'b1; mem_data = 16'h0001;
        mid();
        chk16("upd2_PCside", PCside, 16'hFFFF);

        // HOLD -> UPDATE mode 0, address logic wraps to 0.
        nc(); mem_ack = 1'b0; next_valid = 1'b1; next_mode = 3'd0;
        nc(); next_valid = 1'b0; ALout = 16'h0000;
        mid();
        chk1("wrap_PCplus1", PCplus1, 1'b1);

        // FETCH with no acknowledge: times out in the 15th cycle.
        nc(); ALout = 16'h7777;
        mid();
        chk16("wrap_PCside", PCside, 16'h0000);
        repeat (13) nc();
        mid();
        chk1("to_c14_no_err", fetch_err, 1'b0);
        nc();
        mid();
        chk1("to_c15_err", fetch_err, 1'b1);
        nc(); ALout = 16'h0040;
        mid();
        chk1("to_ResetPC", ResetPC, 1'b1);
        chk1("to_err_pulse_ends", fetch_err, 1'b0);

        // FETCH acknowledged in exactly the 15th cycle: success.
        nc();
        mid();
        chk16("late_PCside", PCside, 16'h0040);
        repeat (14) nc();
        mem_ack = 1'b1; mem_data = 16'h7E00;
        mid();
        chk1("late_no_err", fetch_err, 1'b0);
        nc(); mem_ack = 1'b0; next_valid = 1'b1; next_mode = 3'd6;
        mid();
        chk1("late_instr_valid", instr_valid, 1'b1);
        chk16("late_IR", IR, 16'h7E00);

        // UPDATE with illegal mode 6.
        nc(); next_valid = 1'b0; ALout = 16'h0041;
        mid();
        chk1("bad_mode_err", mode_err, 1'b1);
        chk1("bad_PCplus1", PCplus1, 1'b1);
        nc(); mem_ack = 1'b1; mem_data = 16'h0303;
        mid();
        chk1("bad_err_pulse_ends", mode_err, 1'b0);
        chk16("bad_PCside", PCside, 16'h0041);

        // Mode 3, then mode 4.
        nc(); mem_ack = 1'b0; next_valid = 1'b1; next_mode = 3'd3;
        nc(); next_valid = 1'b0; ALout = 16'h0100;
        mid();
        chk1("m3_Rplus0", Rplus0, 1'b1);
        nc(); mem_ack = 1'b1; mem_data = 16'h0404;
        nc(); mem_ack = 1'b0; next_valid = 1'b1; next_mode = 3'd4;
        nc(); next_valid = 1'b0; ALout = 16'h0000;
        mid();
        chk1("m4_ResetPC", ResetPC, 1'b1);
        chk1("m4_no_mode_err", mode_err, 1'b0);
        nc(); mem_ack = 1'b1; mem_data = 16'hCAFE;

        // Reset during HOLD.
        nc(); mem_ack = 1'b0;
        mid();
        chk1("hr_instr_valid_before", instr_valid, 1'b1);
        nc(); rst = 1'b1;
        mid();
        chk1("hr_instr_valid", instr_valid, 1'b0);
        chk1("hr_next_ready", next_ready, 1'b0);
        nc(); rst = 1'b0; ALout = 16'h0200;
        mid();
        chk1("hr_ResetPC", ResetPC, 1'b1);
        chk16("hr_IR", IR, 16'h0000);
        chk16("hr_PCside", PCside, 16'h0000);

        // Reset during FETCH, then a late acknowledge.
        nc();
        nc();
        nc(); rst = 1'b1;
        mid();
        chk1("fr_mem_rd", mem_rd, 1'b0);
        nc(); rst = 1'b0; mem_ack = 1'b1; mem_data = 16'hBAD0;
        mid();
        chk1("fr_ResetPC", ResetPC, 1'b1);
        chk1("fr_mem_rd_idle", mem_rd, 1'b0);
        nc(); mem_ack = 1'b0;
        mid();
        chk16("fr_IR_kept", IR, 16'h0000);
        chk1("fr_instr_valid", instr_valid, 1'b0);
        chk1("fr_mem_rd", mem_rd, 1'b1);
        repeat (3) nc();

        mid();
        chk1("sb_drained", (exp_q.size() == 0), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog expired");
    end

endmodule
